// File: rtl/apb_pkg.sv
// apb_pkg: definitions shared by the APB requester (apb_master) and the
// APB completer (apb_slave).
//   apb_state_t     - transfer phase: IDLE, SETUP, ACCESS
//   APB_ADDR_WIDTH  - default address width
//   APB_DATA_WIDTH  - default data width
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

endpackage

// File: rtl/apb_master_wdog.sv
// apb_master_wdog: counts ACCESS cycles spent with pready low and flags the
// cycle in which the count reaches TIMEOUT_CYCLES. It is built only when
// APB_TIMEOUT_EN is defined.
// Ports:
//   pclk     in  clock, rising edge
//   prst     in  asynchronous active-low reset
//   clear    in  restart the count (asserted in SETUP, i.e. just before ACCESS)
//   waiting  in  ACCESS cycle with pready low
//   expired  out this waiting cycle is the TIMEOUT_CYCLES-th one
module apb_master_wdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic pclk,
  input  logic prst,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // cnt_q holds the number of earlier pready-low cycles, so the current
  // cycle is the last allowed one when it equals TIMEOUT_CYCLES-1.
  assign expired = waiting && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (waiting && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/apb_master.sv
// apb_master: APB requester. Converts a valid/ready command stream into APB
// SETUP/ACCESS transfers (one outstanding) and returns read data and error on
// a valid/ready response channel.
// Optional feature: define APB_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles of pready low (response with rsp_err=1, rsp_rdata=0).
// Ports:
//   pclk, prst                       clock / asynchronous active-low reset
//   cmd_valid, cmd_ready             command handshake
//   cmd_write, cmd_addr, cmd_wdata   command payload
//   rsp_valid, rsp_ready             response handshake
//   rsp_rdata, rsp_err               response payload
//   psel, pen, pwrite, paddr, pwdata APB request outputs
//   prdata, pready, pslverr          APB completer inputs
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  pen,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_t            state_q, state_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  // Goes high on the first clock after reset release; keeps cmd_ready low
  // while prst is asserted without routing the reset into logic.
  logic                  live_q;
  logic                  timeout;
  logic                  accept;

`ifdef APB_TIMEOUT_EN
  apb_master_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .pclk   (pclk),
    .prst   (prst),
    .clear  (state_q == SETUP),
    .waiting(state_q == ACCESS && !pready),
    .expired(timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // A pending response blocks new commands unless it is consumed this cycle.
  assign cmd_ready = live_q && (state_q == IDLE) && (!rsp_valid_q || rsp_ready);
  assign accept    = cmd_valid && cmd_ready;

  assign psel      = (state_q != IDLE);
  assign pen       = (state_q == ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;

    if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SETUP;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
        end else if (timeout) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      live_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      live_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized scoreboard bench for apb_master with a
// behavioural APB completer and a reference memory model.
module tb_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef APB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          pclk = 1'b0;
  logic          prst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel;
  logic          pen;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  apb_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk     (pclk),
    .prst     (prst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .pen      (pen),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr)
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rsp = 0;
  int cyc   = 0;
  always @(posedge pclk) cyc++;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic [AW-1:0] addr;
    logic          wr;
  } rsp_t;

  rsp_t          exp_q[$];
  rsp_t          sb_e;
  logic [DW-1:0] ref_mem[logic [AW-1:0]];
  logic [DW-1:0] slv_mem[logic [AW-1:0]];
  int            force_waits = -1;
  bit            stuck = 1'b0;
  int            rr_mode = 0;  // 0 random, 1 hold low, 2 hold high

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  function automatic logic err_addr(input logic [AW-1:0] a);
    return a[5:2] == 4'hF;
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // APB completer: random wait states, errors on a fixed address class,
  // random garbage on pready/prdata/pslverr whenever it must be ignored.
  int waits_left = 0;
  always @(posedge pclk) begin
    #1;
    pready  = 1'($urandom_range(0, 1));
    prdata  = $urandom;
    pslverr = 1'($urandom_range(0, 1));
    if (prst && psel && !pen) begin
      waits_left = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
    end else if (prst && psel && pen) begin
      if (stuck || waits_left > 0) begin
        pready = 1'b0;
        if (!stuck) waits_left--;
      end else begin
        pready  = 1'b1;
        pslverr = err_addr(paddr);
        prdata  = slv_mem.exists(paddr) ? slv_mem[paddr] : init_val(paddr);
        if (pwrite && !pslverr) slv_mem[paddr] = pwdata;
      end
    end
  end

  always @(posedge pclk) begin
    #1;
    if (rr_mode == 1) rsp_ready = 1'b0;
    else if (rr_mode == 2) rsp_ready = 1'b1;
    else rsp_ready = ($urandom_range(0, 3) != 0);
  end

  // Protocol monitor: expected APB phase sequence after each accept.
  int            ph = 0;
  int            acc_n = 0;
  logic          lw;
  logic [AW-1:0] la;
  logic [DW-1:0] ld;
  always @(negedge pclk) begin
    if (!prst) begin
      ph = 0;
    end else begin
      case (ph)
        1: begin
          check("setup_psel", psel, 1);
          check("setup_pen", pen, 0);
          check("setup_paddr", paddr, la);
          check("setup_pwrite", pwrite, lw);
          if (lw) check("setup_pwdata", pwdata, ld);
          check("setup_cmd_ready", cmd_ready, 0);
          ph = 2;
          acc_n = 0;
        end
        2: begin
          acc_n++;
          check("access_psel", psel, 1);
          check("access_pen", pen, 1);
          check("access_paddr", paddr, la);
          check("access_pwrite", pwrite, lw);
          check("access_cmd_ready", cmd_ready, 0);
          if (pready) ph = 3;
          else if (TO_EN && acc_n == TO) ph = 3;
        end
        3: begin
          check("done_psel", psel, 0);
          check("done_pen", pen, 0);
          check("done_rsp_valid", rsp_valid, 1);
          check("done_paddr_hold", paddr, la);
          ph = 0;
        end
        default: begin
          check("idle_psel", psel, 0);
          check("idle_pen", pen, 0);
        end
      endcase
      if (rsp_valid && !rsp_ready) check("held_cmd_ready", cmd_ready, 0);
      if (cmd_valid && cmd_ready) begin
        check("accept_phase", ph, 0);
        la = cmd_addr;
        lw = cmd_write;
        ld = cmd_wdata;
        ph = 1;
      end
    end
  end

  // Scoreboard monitor.
  always @(negedge pclk) begin
    if (prst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rdata=%08h err=%0b expected no response", rsp_rdata, rsp_err);
      end else begin
        sb_e = exp_q.pop_front();
        n_rsp++;
        $display("rsp %0d %s addr=%08h rdata=%08h err=%0b", n_rsp, sb_e.wr ? "WR" : "RD",
                 sb_e.addr, rsp_rdata, rsp_err);
        check("rsp_rdata", rsp_rdata, sb_e.rdata);
        check("rsp_err", rsp_err, sb_e.err);
      end
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit tmo);
    rsp_t e;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int c = 0; c < 100; c++) begin
      @(negedge pclk);
      if (cmd_ready) break;
    end
    check("cmd_accept", cmd_ready, 1);
    if (cmd_ready) begin
      e.wr   = wr;
      e.addr = a;
      if (tmo) begin
        e.rdata = '0;
        e.err   = 1'b1;
      end else begin
        e.err   = err_addr(a);
        e.rdata = wr ? '0 : (ref_mem.exists(a) ? ref_mem[a] : init_val(a));
        if (wr && !e.err) ref_mem[a] = d;
      end
      exp_q.push_back(e);
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic drain();
    cmd_valid = 1'b0;
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(posedge pclk);
    repeat (2) @(posedge pclk);
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  int last_acc;

  initial begin
    #12;
    check("rst_psel", psel, 0);
    check("rst_pen", pen, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    #9 prst = 1'b1;
    @(posedge pclk);
    #1;

    // Directed: zero-wait write then 1-wait read of the same word.
    rr_mode = 2;
    force_waits = 0;
    issue(1'b1, 32'h4, 32'hDEADBEEF, 1'b0);
    drain();
    force_waits = 1;
    issue(1'b0, 32'h4, 32'h0, 1'b0);
    drain();

    // Error read with response held for 5 cycles.
    force_waits = 0;
    rr_mode = 1;
    rsp_ready = 1'b0;
    issue(1'b0, 32'h3C, 32'h0, 1'b0);
    cmd_valid = 1'b1;  // a waiting command must not be accepted
    cmd_addr  = 32'h8;
    cmd_write = 1'b0;
    for (int c = 0; c < 50 && !rsp_valid; c++) @(negedge pclk);
    check("err_rsp_seen", rsp_valid, 1);
    repeat (5) begin
      @(negedge pclk);
      check("held_rsp_valid", rsp_valid, 1);
      check("held_cmd_ready_err", cmd_ready, 0);
    end
    cmd_valid = 1'b0;
    @(posedge pclk);
    #1;
    rr_mode = 2;
    rsp_ready = 1'b1;
    drain();

    // Back-to-back: held cmd_valid, rsp_ready high, accepts every 3 cycles.
    issue(1'b1, 32'h10, 32'h1111_0001, 1'b0);
    last_acc = cyc;
    for (int i = 1; i < 4; i++) begin
      issue(i[0], 32'h10 + 32'(i * 4), $urandom, 1'b0);
      check("b2b_spacing", cyc - last_acc, 3);
      last_acc = cyc;
    end
    drain();

    // Reset during ACCESS.
    stuck = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 1'b0);
    cmd_valid = 1'b0;
    @(posedge pclk);
    #3 prst = 1'b0;
    #1;
    check("arst_psel", psel, 0);
    check("arst_pen", pen, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    check("arst_cmd_ready", cmd_ready, 0);
    exp_q.delete();
    stuck = 1'b0;
    repeat (2) @(posedge pclk);
    #1 prst = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    @(posedge pclk);
    #1;
    issue(1'b1, 32'h24, 32'hCAFE_F00D, 1'b0);
    issue(1'b0, 32'h24, 32'h0, 1'b0);
    drain();

`ifdef APB_TIMEOUT_EN
    stuck = 1'b1;
    issue(1'b0, 32'h28, 32'h0, 1'b1);
    drain();
    issue(1'b1, 32'h2C, 32'h1234_5678, 1'b1);
    drain();
    stuck = 1'b0;
`endif

    // Randomized traffic.
    force_waits = -1;
    rr_mode = 0;
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)) << 2, $urandom, 1'b0);
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(0, 2)));
    end
    rr_mode = 2;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, got time %0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
